// File: rtl/remote_update_rd_fifo_pkg.sv
// rtl/remote_update_rd_fifo_pkg.sv - shared widths and default depths/watermarks for the remote-update read FIFO
package remote_update_pkg;

    localparam int RU_BYTE_W       = 8;
    localparam int RU_WORD_W       = 32;
    localparam int RU_WR_DEPTH_W   = 11;
    localparam int RU_RD_DEPTH_W   = 9;
    localparam int RU_ALMOST_FULL  = 2000;
    localparam int RU_ALMOST_EMPTY = 4;

endpackage

// File: rtl/remote_update_rd_fifo_if.sv
// rtl/remote_update_rd_fifo_if.sv - byte-write / word-read port bundle of the remote-update read FIFO
interface remote_update_rd_fifo_if
    import remote_update_pkg::*;
#(
    parameter int WR_DEPTH_WIDTH = RU_WR_DEPTH_W,
    parameter int RD_DEPTH_WIDTH = RU_RD_DEPTH_W
);

    logic [RU_BYTE_W-1:0]    wr_data;
    logic                    wr_en;
    logic                    wr_full;
    logic                    almost_full;
    logic [WR_DEPTH_WIDTH:0] wr_water_level;
    logic [RU_WORD_W-1:0]    rd_data;
    logic                    rd_en;
    logic                    rd_empty;
    logic [RD_DEPTH_WIDTH:0] rd_water_level;
    logic                    almost_empty;

    modport master (
        output wr_data, wr_en, rd_en,
        input  wr_full, almost_full, wr_water_level,
        input  rd_data, rd_empty, rd_water_level, almost_empty
    );

    modport slave (
        input  wr_data, wr_en, rd_en,
        output wr_full, almost_full, wr_water_level,
        output rd_data, rd_empty, rd_water_level, almost_empty
    );

endinterface

// File: rtl/remote_update_rd_fifo_byte_packer.sv
// rtl/remote_update_rd_fifo_byte_packer.sv - little-endian byte-to-word packer; commit strobes on the fourth accepted byte
module remote_update_byte_packer
    import remote_update_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [RU_BYTE_W-1:0] data,
    input  logic                 accept,
    output logic [1:0]           byte_cnt_next,
    output logic                 commit,
    output logic [RU_WORD_W-1:0] word
);

    logic [1:0]  byte_cnt;
    logic [23:0] pack;

    // The fourth byte is never registered: it goes straight into the committed word.
    always_comb begin
        byte_cnt_next = accept ? byte_cnt + 2'd1 : byte_cnt;
        commit        = accept && (byte_cnt == 2'd3);
        word          = {data, pack};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt <= 2'd0;
            pack     <= 24'd0;
        end else if (accept) begin
            byte_cnt <= byte_cnt_next;
            case (byte_cnt)
                2'd0:    pack[7:0]   <= data;
                2'd1:    pack[15:8]  <= data;
                2'd2:    pack[23:16] <= data;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/remote_update_rd_fifo.sv
// rtl/remote_update_rd_fifo.sv - flash read-back FIFO: bytes in, 32-bit words out, registered levels/flags.
// Optional rd_data output register: REMOTE_UPDATE_RD_FIFO_OUTPUT_REG_EN.
module remote_update_rd_fifo
    import remote_update_pkg::*;
#(
    parameter int WR_DEPTH_WIDTH   = RU_WR_DEPTH_W,
    parameter int RD_DEPTH_WIDTH   = RU_RD_DEPTH_W,
    parameter int ALMOST_FULL_NUM  = RU_ALMOST_FULL,
    parameter int ALMOST_EMPTY_NUM = RU_ALMOST_EMPTY
) (
    input  logic                   clk,
    input  logic                   rst,
    remote_update_rd_fifo_if.slave bus
);

    localparam int                      DEPTH    = 2 ** RD_DEPTH_WIDTH;
    localparam logic [RD_DEPTH_WIDTH:0] PTR_ONE  = 1;
    localparam logic [RD_DEPTH_WIDTH:0] FULL_CNT = (RD_DEPTH_WIDTH + 1)'(DEPTH);
    localparam logic [WR_DEPTH_WIDTH:0] AF_LVL   = (WR_DEPTH_WIDTH + 1)'(ALMOST_FULL_NUM);
    localparam logic [RD_DEPTH_WIDTH:0] AE_LVL   = (RD_DEPTH_WIDTH + 1)'(ALMOST_EMPTY_NUM);

    logic [RU_WORD_W-1:0]    mem [DEPTH];
    logic [RD_DEPTH_WIDTH:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, cnt_nxt;
    logic [WR_DEPTH_WIDTH:0] wr_lvl_nxt, wr_lvl_q;
    logic [RD_DEPTH_WIDTH:0] rd_lvl_q;
    logic                    full_q, empty_q, af_q, ae_q;
    logic                    wr_accept, rd_accept, commit;
    logic [1:0]              byte_cnt_next;
    logic [RU_WORD_W-1:0]    commit_word, rd_q;

    remote_update_byte_packer u_packer (
        .clk           (clk),
        .rst           (rst),
        .data          (bus.wr_data),
        .accept        (wr_accept),
        .byte_cnt_next (byte_cnt_next),
        .commit        (commit),
        .word          (commit_word)
    );

    // Flags are registered from the post-edge pointer/counter values, so they need no decode delay.
    always_comb begin
        wr_accept  = bus.wr_en && !full_q;
        rd_accept  = bus.rd_en && !empty_q;
        wr_ptr_nxt = commit ? wr_ptr + PTR_ONE : wr_ptr;
        rd_ptr_nxt = rd_accept ? rd_ptr + PTR_ONE : rd_ptr;
        cnt_nxt    = wr_ptr_nxt - rd_ptr_nxt;
        wr_lvl_nxt = (WR_DEPTH_WIDTH + 1)'({cnt_nxt, 2'b00}) + (WR_DEPTH_WIDTH + 1)'(byte_cnt_next);
    end

    always_ff @(posedge clk) begin
        if (commit) mem[wr_ptr[RD_DEPTH_WIDTH-1:0]] <= commit_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_q     <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            wr_lvl_q <= '0;
            rd_lvl_q <= '0;
        end else begin
            wr_ptr   <= wr_ptr_nxt;
            rd_ptr   <= rd_ptr_nxt;
            if (rd_accept) rd_q <= mem[rd_ptr[RD_DEPTH_WIDTH-1:0]];
            full_q   <= (cnt_nxt == FULL_CNT);
            empty_q  <= (cnt_nxt == '0);
            af_q     <= (wr_lvl_nxt >= AF_LVL);
            ae_q     <= (cnt_nxt <= AE_LVL);
            wr_lvl_q <= wr_lvl_nxt;
            rd_lvl_q <= cnt_nxt;
        end
    end

`ifdef REMOTE_UPDATE_RD_FIFO_OUTPUT_REG_EN
    logic [RU_WORD_W-1:0] rd_out_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_out_q <= '0;
        else     rd_out_q <= rd_q;
    end

    assign bus.rd_data = rd_out_q;
`else
    assign bus.rd_data = rd_q;
`endif

    assign bus.wr_full        = full_q;
    assign bus.almost_full    = af_q;
    assign bus.wr_water_level = wr_lvl_q;
    assign bus.rd_empty       = empty_q;
    assign bus.rd_water_level = rd_lvl_q;
    assign bus.almost_empty   = ae_q;

endmodule

// File: tb/tb_remote_update_rd_fifo.sv
// tb/tb_remote_update_rd_fifo.sv - scoreboard bench for remote_update_rd_fifo (directed vectors)
module tb_remote_update_rd_fifo;
    import remote_update_pkg::*;

`ifdef REMOTE_UPDATE_RD_FIFO_OUTPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    remote_update_rd_fifo_if bus ();

    remote_update_rd_fifo dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] exp_q[$];
    logic        rd_exp = 1'b0;
    logic [1:0]  fire_d = 2'b00;
    int          m_words, m_bytes;
    logic [31:0] m_pack;

    always @(posedge clk or posedge rst) begin
        if (rst) fire_d <= 2'b00;
        else     fire_d <= {fire_d[0], rd_exp};
    end

    always @(negedge clk) begin
        if (fire_d[LAT-1]) begin
            logic [31:0] e;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL sb_underflow rd_data=%08h required=<no word queued>", bus.rd_data);
            end else begin
                e = exp_q.pop_front();
                if (bus.rd_data !== e) begin
                    miscompares++;
                    $display("FAIL sb_rd_data actual=%08h required=%08h", bus.rd_data, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_state();
        int lvl;
        lvl = m_words * 4 + m_bytes;
        check("wr_water_level", 32'(bus.wr_water_level), 32'(lvl));
        check("rd_water_level", 32'(bus.rd_water_level), 32'(m_words));
        check("wr_full",        32'(bus.wr_full),        32'(m_words == 512));
        check("rd_empty",       32'(bus.rd_empty),       32'(m_words == 0));
        check("almost_full",    32'(bus.almost_full),    32'(lvl >= 2000));
        check("almost_empty",   32'(bus.almost_empty),   32'(m_words <= 4));
    endtask

    task automatic check_reset();
        check("rst_rd_data",        bus.rd_data,                 32'h0);
        check("rst_rd_empty",       32'(bus.rd_empty),           32'd1);
        check("rst_almost_empty",   32'(bus.almost_empty),       32'd1);
        check("rst_wr_full",        32'(bus.wr_full),            32'd0);
        check("rst_almost_full",    32'(bus.almost_full),        32'd0);
        check("rst_wr_water_level", 32'(bus.wr_water_level),     32'd0);
        check("rst_rd_water_level", 32'(bus.rd_water_level),     32'd0);
    endtask

    // One clock of stimulus; the expected word is queued when its fourth byte is accepted.
    task automatic step(input bit we, input logic [7:0] d, input bit re);
        bit wacc, racc;
        wacc = we && (m_words < 512);
        racc = re && (m_words > 0);
        bus.wr_en   = we;
        bus.wr_data = d;
        bus.rd_en   = re;
        rd_exp      = racc;
        if (wacc) begin
            if (m_bytes == 3) begin
                exp_q.push_back({d, m_pack[23:0]});
                m_words++;
                m_bytes = 0;
            end else begin
                m_pack[m_bytes*8 +: 8] = d;
                m_bytes++;
            end
        end
        if (racc) m_words--;
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        rd_exp    = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        bus.rd_en   = 1'b0;
        m_words = 0;
        m_bytes = 0;
        m_pack  = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check_reset();
        rst = 1'b0;

        // Eight bytes -> two packed words, then drain.
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 8'(i), 1'b0);
            check_state();
        end
        check("two_words_level", 32'(bus.rd_water_level), 32'd2);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        idle(3);
        check("drain_rd_empty", 32'(bus.rd_empty), 32'd1);
        check("drain_last_word", bus.rd_data, 32'h08070605);

        // Read while empty leaves data and levels alone.
        step(1'b0, 8'h00, 1'b1);
        idle(2);
        check("empty_rd_hold", bus.rd_data, 32'h08070605);
        check_state();

        // Fill to full, watching the watermark boundaries.
        for (int i = 0; i < 2048; i++) begin
            step(1'b1, 8'(i * 7 + 3), 1'b0);
            check_state();
            if (i == 15)   check("ae_at_4_words",   32'(bus.almost_empty), 32'd1);
            if (i == 19)   check("ae_at_5_words",   32'(bus.almost_empty), 32'd0);
            if (i == 1998) check("af_at_1999",      32'(bus.almost_full),  32'd0);
            if (i == 1999) check("af_at_2000",      32'(bus.almost_full),  32'd1);
        end
        check("full_flag",  32'(bus.wr_full),        32'd1);
        check("full_level", 32'(bus.wr_water_level), 32'd2048);
        step(1'b1, 8'hEE, 1'b0);
        check("drop_level", 32'(bus.wr_water_level), 32'd2048);
        check_state();
        step(1'b0, 8'h00, 1'b1);
        check("after_rd_full",  32'(bus.wr_full),        32'd0);
        check("after_rd_level", 32'(bus.wr_water_level), 32'd2044);

        // Top up, drop to 300 words, then stream three full pointer passes.
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h90 + i), 1'b0);
        check_state();
        for (int i = 0; i < 212; i++) step(1'b0, 8'h00, 1'b1);
        check("steady_start", 32'(bus.rd_water_level), 32'd300);
        for (int w = 0; w < 1536; w++) begin
            for (int b = 0; b < 4; b++) begin
                step(1'b1, 8'(w * 13 + b * 5 + 1), b == 3);
                if (b == 3) check("steady_level", 32'(bus.rd_water_level), 32'd300);
            end
        end
        for (int k = 0; k < 600 && m_words > 0; k++) step(1'b0, 8'h00, 1'b1);
        idle(3);
        check_state();

        // Reset mid-word discards the partial bytes.
        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        step(1'b1, 8'h33, 1'b0);
        rst = 1'b1;
        #1;
        check_reset();
        m_words = 0;
        m_bytes = 0;
        m_pack  = 32'h0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b1, 8'hAA, 1'b0);
        step(1'b1, 8'hBB, 1'b0);
        step(1'b1, 8'hCC, 1'b0);
        step(1'b1, 8'hDD, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        idle(2);
        check("post_rst_word", bus.rd_data, 32'hDDCCBBAA);
        check_state();

        idle(3);
        check("sb_leftover", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
